multi_cycle_ctrl: RTL
=====================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameters: none; all encodings are fixed constants from the shared package.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 OpCode  in  6  IR[31:26]; valid from ID onward.
REQ-005 Funct  in  6  IR[5:0]; valid from ID onward.
REQ-006 mem_ready  in  1  memory access complete; used only under MEM_WAIT_EN.
REQ-007 PCWrite, PCWriteCond, IRWrite, RegWrite  out  1 each  write strobes.
REQ-008 MemRead, MemWrite  out  1 each  memory strobes.
REQ-009 IorD  out  1  0 = PC address, 1 = ALUOut address.
REQ-010 RegDst  out  2  0 = rt, 1 = rd, 2 = $31.
REQ-011 MemtoReg  out  2  0 = ALUOut, 1 = MDR, 2 = PC.
REQ-012 ALUSrcA  out  2  0 = PC, 1 = rs, 2 = shamt.
REQ-013 ALUSrcB  out  2  0 = rt, 1 = const 4, 2 = ext imm, 3 = ext imm<<2.
REQ-014 PCSource  out  2  0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs.
REQ-015 ALUOp  out  3  000 ADD, 001 SUB, 010 FUNCT, 011 AND, 100 SLT, 101 LUI; feeds ALU control.
REQ-016 state  out  3  current state (debug); illegal  out  1  one-cycle undecodable-instruction pulse.

Function
REQ-017 States: IF=0, ID=1, EX=2, MEM=3, WB=4; outputs decoded combinationally from state, OpCode, Funct.
REQ-018 IF: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0, PCWrite=1; next ID.
REQ-019 ID: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (branch target into ALUOut).
REQ-020 ID for j: PCWrite=1, PCSource=2; jal additionally RegWrite=1, RegDst=2, MemtoReg=2; jr: PCWrite=1, PCSource=3; jalr: jr plus RegWrite=1, RegDst=1, MemtoReg=2; next IF (2 cycles).
REQ-021 ID for all other legal opcodes goes to EX; undecodable opcode/funct: illegal=1, no strobes, next IF.
REQ-022 EX R-type: ALUSrcA=2 for sll/srl/sra else 1, ALUSrcB=0, ALUOp=FUNCT; next WB (4 cycles).
REQ-023 EX lw/sw (0x23/0x2b): ALUSrcA=1, ALUSrcB=2, ALUOp=ADD; next MEM.
REQ-024 EX beq (0x04): ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCWriteCond=1, PCSource=1; next IF (3 cycles).
REQ-025 EX I-ALU: ALUSrcA=1, ALUSrcB=2; ALUOp ADD for 0x08/0x09, AND for 0x0c, SLT for 0x0a/0x0b, LUI for 0x0f; next WB.
REQ-026 MEM: IorD=1; lw MemRead=1 then WB (5 cycles); sw MemWrite=1 then IF (4 cycles).
REQ-027 WB: RegWrite=1; R-type RegDst=1, MemtoReg=0; lw RegDst=0, MemtoReg=1; I-ALU RegDst=0, MemtoReg=0; next IF.
REQ-028 Strobes not named for a state/instruction are 0; unnamed selects are don't-care but driven 0.

Reset
REQ-029 While reset=1: all strobes and illegal forced 0; next state IF, regardless of current state (mid-wait included).
REQ-030 First cycle after reset deasserts is IF with IF outputs.

Configuration
REQ-031 Macro MULTI_CYCLE_MEM_WAIT_EN: defined -> IF and MEM hold while mem_ready=0, memory strobes held, IRWrite/PCWrite asserted only in the mem_ready=1 cycle; undefined -> mem_ready ignored, IF/MEM are one cycle.

Structure
REQ-032 Shared package multi_cycle_pkg: state encodings, ALUOp codes, all mux-select constants, opcode/funct constants.
REQ-033 One sub-module instr_class_dec: OpCode/Funct -> class {R, SHIFT, LW, SW, BEQ, J, JAL, JR, JALR, IALU, ILLEGAL}.

Verification
REQ-034 add (OpCode 0x00, Funct 0x20): states 0,1,2,4,0; RegWrite=1, RegDst=1 only in WB.
REQ-035 lw (0x23) with MEM_WAIT_EN, mem_ready low 3 MEM cycles: MEM held 4 cycles, MemRead=1 throughout, then WB MemtoReg=1.
REQ-036 beq (0x04): 3 cycles; EX PCWriteCond=1, PCSource=1, ALUOp=001.
REQ-037 jal (0x03): 2 cycles; ID PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2.
REQ-038 OpCode 0x3f: ID illegal=1, all strobes 0, next IF; reset asserted in MEM of sw -> MemWrite=0 immediately, IF after release.

Source files
------------

// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle MIPS-style controller: FSM states,
// ALU operation codes, datapath mux selects, opcode/funct values and instruction classes.
package multi_cycle_pkg;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [3:0] {
    CLS_R, CLS_SHIFT, CLS_LW, CLS_SW, CLS_BEQ, CLS_J,
    CLS_JAL, CLS_JR, CLS_JALR, CLS_IALU, CLS_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic       iord;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic [2:0] ialu_alu_op(input logic [5:0] opcode);
    case (opcode)
      OP_ANDI:           return ALU_AND;
      OP_SLTI, OP_SLTIU: return ALU_SLT;
      OP_LUI:            return ALU_LUI;
      default:           return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// write strobes and mux selects out. master = controller, slave = datapath.
interface multi_cycle_ctrl_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic [2:0] state;
  logic       illegal;

  modport master (
    input  OpCode, Funct, mem_ready,
    output PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, IorD,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, state, illegal
  );

  modport slave (
    output OpCode, Funct, mem_ready,
    input  PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, IorD,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, state, illegal
  );
endinterface

// File: rtl/multi_cycle_ctrl_instr_class_dec.sv
// Maps OpCode/Funct onto the instruction class the controller sequences by;
// anything not listed is CLS_ILLEGAL.
module instr_class_dec
  import multi_cycle_pkg::*;
(
  input  logic [5:0]   OpCode,
  input  logic [5:0]   Funct,
  output instr_class_e cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (OpCode)
      OP_RTYPE: begin
        case (Funct)
          FN_SLL, FN_SRL, FN_SRA: cls = CLS_SHIFT;
          FN_JR:                  cls = CLS_JR;
          FN_JALR:                cls = CLS_JALR;
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: cls = CLS_R;
          default:                cls = CLS_ILLEGAL;
        endcase
      end
      OP_J:   cls = CLS_J;
      OP_JAL: cls = CLS_JAL;
      OP_BEQ: cls = CLS_BEQ;
      OP_LW:  cls = CLS_LW;
      OP_SW:  cls = CLS_SW;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: cls = CLS_IALU;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle controller FSM (IF/ID/EX/MEM/WB), outputs decoded from state and class.
// Define MULTI_CYCLE_MEM_WAIT_EN to stall IF and MEM until mem_ready.
module multi_cycle_ctrl
  import multi_cycle_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  multi_cycle_ctrl_if.master  bus
);

  logic [2:0]   state_q;
  logic [2:0]   state_nxt;
  instr_class_e cls;
  ctrl_t        c;
  logic         mem_done;

  instr_class_dec u_dec (
    .OpCode (bus.OpCode),
    .Funct  (bus.Funct),
    .cls    (cls)
  );

`ifdef MULTI_CYCLE_MEM_WAIT_EN
  assign mem_done = bus.mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  always_comb begin
    c         = '0;
    state_nxt = S_IF;
    case (state_q)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        // Architectural writes only land in the cycle the fetch completes.
        c.ir_write  = mem_done;
        c.pc_write  = mem_done;
        state_nxt   = mem_done ? S_ID : S_IF;
      end
      S_ID: begin
        c.alu_src_b = SRCB_IMM_SH;
        state_nxt   = S_EX;
        case (cls)
          CLS_J: begin
            c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP; state_nxt = S_IF;
          end
          CLS_JAL: begin
            c.pc_write  = 1'b1; c.pc_source  = PCSRC_JUMP;
            c.reg_write = 1'b1; c.reg_dst    = REGDST_RA; c.mem_to_reg = M2R_PC;
            state_nxt   = S_IF;
          end
          CLS_JR: begin
            c.pc_write = 1'b1; c.pc_source = PCSRC_RS; state_nxt = S_IF;
          end
          CLS_JALR: begin
            c.pc_write  = 1'b1; c.pc_source  = PCSRC_RS;
            c.reg_write = 1'b1; c.reg_dst    = REGDST_RD; c.mem_to_reg = M2R_PC;
            state_nxt   = S_IF;
          end
          CLS_ILLEGAL: begin
            c.illegal = 1'b1; state_nxt = S_IF;
          end
          default: ;
        endcase
      end
      S_EX: begin
        state_nxt = S_WB;
        case (cls)
          CLS_R:     begin c.alu_src_a = SRCA_RS;    c.alu_op = ALU_FUNCT; end
          CLS_SHIFT: begin c.alu_src_a = SRCA_SHAMT; c.alu_op = ALU_FUNCT; end
          CLS_LW, CLS_SW: begin
            c.alu_src_a = SRCA_RS; c.alu_src_b = SRCB_IMM; state_nxt = S_MEM;
          end
          CLS_BEQ: begin
            c.alu_src_a     = SRCA_RS;  c.alu_op    = ALU_SUB;
            c.pc_write_cond = 1'b1;     c.pc_source = PCSRC_ALUOUT;
            state_nxt       = S_IF;
          end
          CLS_IALU: begin
            c.alu_src_a = SRCA_RS; c.alu_src_b = SRCB_IMM;
            c.alu_op    = ialu_alu_op(bus.OpCode);
          end
          default: state_nxt = S_IF;
        endcase
      end
      S_MEM: begin
        c.iord      = 1'b1;
        c.mem_read  = (cls == CLS_LW);
        c.mem_write = (cls == CLS_SW);
        if (!mem_done)          state_nxt = S_MEM;
        else if (cls == CLS_LW) state_nxt = S_WB;
        else                    state_nxt = S_IF;
      end
      S_WB: begin
        c.reg_write = 1'b1;
        case (cls)
          CLS_R, CLS_SHIFT: c.reg_dst    = REGDST_RD;
          CLS_LW:           c.mem_to_reg = M2R_MDR;
          default: ;
        endcase
      end
      default: state_nxt = S_IF;
    endcase
    // Reset silences every strobe at once, even mid-wait.
    if (reset) c = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_nxt;
  end

  assign bus.PCWrite     = c.pc_write;
  assign bus.PCWriteCond = c.pc_write_cond;
  assign bus.IRWrite     = c.ir_write;
  assign bus.RegWrite    = c.reg_write;
  assign bus.MemRead     = c.mem_read;
  assign bus.MemWrite    = c.mem_write;
  assign bus.IorD        = c.iord;
  assign bus.RegDst      = c.reg_dst;
  assign bus.MemtoReg    = c.mem_to_reg;
  assign bus.ALUSrcA     = c.alu_src_a;
  assign bus.ALUSrcB     = c.alu_src_b;
  assign bus.PCSource    = c.pc_source;
  assign bus.ALUOp       = c.alu_op;
  assign bus.illegal     = c.illegal;
  assign bus.state       = state_q;

endmodule
